// File: rtl/fixed_mac_pipe.sv
// Signed fixed-point multiply-accumulate with a 2-stage valid/ready pipeline.
// S1 holds the raw full-width product; S2 accumulates, rounds and saturates to W/F.
module fixed_mac_pipe #(
  parameter int W     = 8,
  parameter int F     = 6,
  parameter int ACC_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                acc_en,
  input  logic                clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out,
  output logic                sat,
  output logic                acc_ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [W-1:0]     OUT_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]     OUT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   RND_HALF = (ACC_W+1)'(2 ** (F-1));

  logic                      advance;

  logic                      s1_valid_reg;
  logic signed [2*W-1:0]     prod_reg;
  logic                      acc_en_reg;
  logic                      clr_reg;

  logic signed [ACC_W-1:0]   acc_reg;
  logic                      out_valid_reg;
  logic signed [W-1:0]       out_reg;
  logic                      sat_reg;
  logic                      acc_ovf_reg;

  logic signed [2*W-1:0]     prod_next;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0]     sum_wide;
  logic                      sum_clip;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      acc_ovf_next;
  logic signed [ACC_W:0]     rnd_wide;
  logic signed [ACC_W:0]     shifted;
  logic                      in_range;
  logic signed [W-1:0]       out_next;
  logic                      sat_next;

  // Whole pipeline moves as one; an unconsumed result freezes everything.
  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance;

  assign prod_next = (2*W)'(a) * (2*W)'(b);
  assign prod_ext  = ACC_W'(prod_reg);

  // One extra bit lets the sign disagreement reveal an accumulator overflow.
  assign sum_wide = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(prod_ext);
  assign sum_clip = sum_wide[ACC_W] != sum_wide[ACC_W-1];

  always_comb begin
    acc_next     = prod_ext;
    acc_ovf_next = 1'b0;
    if (!clr_reg && acc_en_reg) begin
      if (sum_clip) begin
        acc_next     = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        acc_ovf_next = 1'b1;
      end else begin
        acc_next     = sum_wide[ACC_W-1:0];
        acc_ovf_next = acc_ovf_reg;
      end
    end
  end

  // Round half up at ACC_W+1 bits so the +half can never wrap a full-scale value.
  assign rnd_wide = (ACC_W+1)'(acc_next) + RND_HALF;
  assign shifted  = rnd_wide >>> F;
  assign in_range = (&shifted[ACC_W:W-1]) | ~(|shifted[ACC_W:W-1]);
  assign out_next = in_range ? shifted[W-1:0] : (shifted[ACC_W] ? OUT_MIN : OUT_MAX);
  assign sat_next = ~in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      prod_reg      <= '0;
      acc_en_reg    <= 1'b0;
      clr_reg       <= 1'b0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      sat_reg       <= 1'b0;
      acc_ovf_reg   <= 1'b0;
    end else if (advance) begin
      s1_valid_reg  <= in_valid;
      prod_reg      <= prod_next;
      acc_en_reg    <= acc_en;
      clr_reg       <= clr;
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        acc_reg     <= acc_next;
        out_reg     <= out_next;
        sat_reg     <= sat_next;
        acc_ovf_reg <= acc_ovf_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign sat       = sat_reg;
  assign acc_ovf   = acc_ovf_reg;

endmodule

// File: tb/tb_fixed_mac_pipe.sv
// Bench for fixed_mac_pipe: directed vectors plus randomized streams scored
// against an arithmetic model of the multiply/accumulate/round/saturate rules.
module tb_fixed_mac_pipe;
  localparam int W = 8;
  localparam int F = 6;
  localparam int ACC_W = 20;
  localparam longint AMAX  = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint AMIN  = -(longint'(1) << (ACC_W-1));
  localparam longint SCALE = longint'(1) << F;
  localparam longint HALF  = longint'(1) << (F-1);
  localparam longint OMAX  = (longint'(1) << (W-1)) - 1;
  localparam longint OMIN  = -(longint'(1) << (W-1));

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] a = '0;
  logic signed [W-1:0] b = '0;
  logic acc_en = 1'b0;
  logic clr = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [W-1:0] out;
  logic sat;
  logic acc_ovf;

  typedef struct packed {
    logic signed [W-1:0] o;
    logic s;
    logic v;
  } res_t;

  res_t   exp_q[$];
  res_t   rx_q[$];
  int     rx_cyc[$];
  int     cyc = 0;
  longint m_acc = 0;
  bit     m_ovf = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;

  fixed_mac_pipe #(.W(W), .F(F), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_en(acc_en), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .sat(sat), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every result that is handed over on the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rx_q.push_back({out, sat, acc_ovf});
      rx_cyc.push_back(cyc);
    end
  end

  function automatic void model_push(int av, int bv, bit ae, bit c);
    longint p = longint'(av) * longint'(bv);
    longint r;
    res_t e;
    if (c || !ae) begin
      m_acc = p;
      m_ovf = 1'b0;
    end else begin
      m_acc = m_acc + p;
      if (m_acc > AMAX) begin m_acc = AMAX; m_ovf = 1'b1; end
      else if (m_acc < AMIN) begin m_acc = AMIN; m_ovf = 1'b1; end
    end
    r = m_acc + HALF;
    r = (r >= 0) ? r / SCALE : -((-r + SCALE - 1) / SCALE);
    e.s = (r > OMAX) || (r < OMIN);
    if (r > OMAX) r = OMAX;
    else if (r < OMIN) r = OMIN;
    e.o = W'(r);
    e.v = m_ovf;
    exp_q.push_back(e);
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic clear_q();
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_en = 1'b0;
    clr = 1'b0;
  endtask

  task automatic send(input int av, input int bv, input bit ae, input bit c);
    int g = 0;
    a = W'(av);
    b = W'(bv);
    acc_en = ae;
    clr = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_accept in_ready=%b required 1", in_ready);
    end else begin
      model_push(av, bv, ae, c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    int g = 0;
    idle();
    while (rx_q.size() < n && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    n_cmp++;
    if (rx_q.size() != n) begin
      n_bad++;
      $display("FAIL result_count got %0d required %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out, sat, acc_ovf, in_ready} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_async got valid=%b out=%0d sat=%b ovf=%b rdy=%b required 0 0 0 0 1",
               out_valid, out, sat, acc_ovf, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_held got valid=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_plain();
    clear_q();
    send(32, 32, 1'b0, 1'b0);
    idle();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL plain_latency_early out_valid=%b required 0", out_valid);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out, sat} !== {1'b1, 8'sd16, 1'b0}) begin
      n_bad++;
      $display("FAIL plain_result got valid=%b out=%0d sat=%b required 1 16 0", out_valid, out, sat);
    end
    collect(1);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      $display("plain txn %0d: out=%0d sat=%b ovf=%b", i, rx_q[i].o, rx_q[i].s, rx_q[i].v);
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL plain_model[%0d] got %0d/%b/%b required %0d/%b/%b", i,
                 rx_q[i].o, rx_q[i].s, rx_q[i].v, exp_q[i].o, exp_q[i].s, exp_q[i].v);
      end
    end
  endtask

  task automatic test_saturation();
    int req_o[2] = '{127, -128};
    clear_q();
    send(-128, -128, 1'b0, 1'b0);
    send(-128, 127, 1'b0, 1'b0);
    collect(2);
    for (int i = 0; i < rx_q.size() && i < 2; i++) begin
      $display("sat txn %0d: out=%0d sat=%b ovf=%b", i, rx_q[i].o, rx_q[i].s, rx_q[i].v);
      n_cmp++;
      if (int'(rx_q[i].o) !== req_o[i] || rx_q[i].s !== 1'b1 || rx_q[i].v !== 1'b0) begin
        n_bad++;
        $display("FAIL saturation[%0d] got out=%0d sat=%b ovf=%b required out=%0d sat=1 ovf=0",
                 i, rx_q[i].o, rx_q[i].s, rx_q[i].v, req_o[i]);
      end
    end
  endtask

  task automatic test_accumulate();
    int req_o[4] = '{32, 64, 96, 127};
    clear_q();
    send(64, 32, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) send(64, 32, 1'b1, 1'b0);
    collect(4);
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      $display("acc txn %0d: out=%0d sat=%b ovf=%b cyc=%0d", i, rx_q[i].o, rx_q[i].s, rx_q[i].v, rx_cyc[i]);
      n_cmp++;
      if (int'(rx_q[i].o) !== req_o[i] || rx_q[i].s !== (i == 3) || rx_q[i].v !== 1'b0) begin
        n_bad++;
        $display("FAIL accumulate[%0d] got out=%0d sat=%b ovf=%b required out=%0d sat=%b ovf=0",
                 i, rx_q[i].o, rx_q[i].s, rx_q[i].v, req_o[i], (i == 3));
      end
      n_cmp++;
      if (rx_cyc[i] - rx_cyc[0] != i) begin
        n_bad++;
        $display("FAIL accumulate_spacing[%0d] got %0d required %0d", i, rx_cyc[i] - rx_cyc[0], i);
      end
    end
  endtask

  task automatic test_rounding();
    int av[4] = '{1, 4, -4, -3};
    int bv[4] = '{1, 8, 8, 11};
    int req_o[4] = '{0, 1, 0, -1};
    clear_q();
    for (int i = 0; i < 4; i++) send(av[i], bv[i], 1'b0, 1'b0);
    collect(4);
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      $display("round txn %0d: product=%0d out=%0d sat=%b", i, av[i] * bv[i], rx_q[i].o, rx_q[i].s);
      n_cmp++;
      if (int'(rx_q[i].o) !== req_o[i] || rx_q[i].s !== 1'b0) begin
        n_bad++;
        $display("FAIL rounding[%0d] got out=%0d sat=%b required out=%0d sat=0",
                 i, rx_q[i].o, rx_q[i].s, req_o[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t held;
    clear_q();
    fork
      begin
        send(rnd8(), rnd8(), 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) send(rnd8(), rnd8(), 1'($urandom_range(0, 1)), 1'b0);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_cmp++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_ready[%0d] got rdy=%b valid=%b required 0 1", k, in_ready, out_valid);
          end
          if (k == 0) begin
            held = {out, sat, acc_ovf};
          end else begin
            n_cmp++;
            if ({out, sat, acc_ovf} !== held) begin
              n_bad++;
              $display("FAIL stall_hold[%0d] got out=%0d sat=%b ovf=%b required out=%0d sat=%b ovf=%b",
                       k, out, sat, acc_ovf, held.o, held.s, held.v);
            end
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    collect(5);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      $display("bp txn %0d: out=%0d sat=%b ovf=%b", i, rx_q[i].o, rx_q[i].s, rx_q[i].v);
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL backpressure[%0d] got %0d/%b/%b required %0d/%b/%b", i,
                 rx_q[i].o, rx_q[i].s, rx_q[i].v, exp_q[i].o, exp_q[i].s, exp_q[i].v);
      end
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    clear_q();
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(rnd8(), rnd8(), 1'($urandom_range(0, 3) != 0), (i == 0) || ($urandom_range(0, 7) == 0));
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    collect(40);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      $display("rand txn %0d: out=%0d sat=%b ovf=%b", i, rx_q[i].o, rx_q[i].s, rx_q[i].v);
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random[%0d] got %0d/%b/%b required %0d/%b/%b", i,
                 rx_q[i].o, rx_q[i].s, rx_q[i].v, exp_q[i].o, exp_q[i].s, exp_q[i].v);
      end
    end
  endtask

  task automatic test_overflow_reset();
    clear_q();
    send(127, 127, 1'b0, 1'b1);
    for (int i = 1; i < 40; i++) send(127, 127, 1'b1, 1'b0);
    collect(40);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      $display("ovf txn %0d: out=%0d sat=%b ovf=%b", i, rx_q[i].o, rx_q[i].s, rx_q[i].v);
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL overflow[%0d] got %0d/%b/%b required %0d/%b/%b", i,
                 rx_q[i].o, rx_q[i].s, rx_q[i].v, exp_q[i].o, exp_q[i].s, exp_q[i].v);
      end
    end
    if (rx_q.size() == 40) begin
      n_cmp++;
      if (rx_q[31].v !== 1'b0 || rx_q[32].v !== 1'b1 || rx_q[39] !== {8'sd127, 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL overflow_edge got ovf31=%b ovf32=%b last=%0d/%b/%b required 0 1 127/1/1",
                 rx_q[31].v, rx_q[32].v, rx_q[39].o, rx_q[39].s, rx_q[39].v);
      end
    end
    clear_q();
    send(10, 10, 1'b0, 1'b1);
    send(20, 20, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle();
    #1;
    n_cmp++;
    if ({out_valid, out, sat, acc_ovf, in_ready} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midstream_reset got valid=%b out=%0d sat=%b ovf=%b rdy=%b required 0 0 0 0 1",
               out_valid, out, sat, acc_ovf, in_ready);
    end
    m_acc = 0;
    m_ovf = 1'b0;
    clear_q();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(50, -40, 1'b1, 1'b0);
    collect(1);
    if (rx_q.size() == 1) begin
      $display("post-reset txn 0: out=%0d sat=%b ovf=%b", rx_q[0].o, rx_q[0].s, rx_q[0].v);
      n_cmp++;
      if (rx_q[0] !== {-8'sd31, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL post_reset got %0d/%b/%b required -31/0/0", rx_q[0].o, rx_q[0].s, rx_q[0].v);
      end
      n_cmp++;
      if (rx_q[0] !== exp_q[0]) begin
        n_bad++;
        $display("FAIL post_reset_model got %0d/%b/%b required %0d/%b/%b",
                 rx_q[0].o, rx_q[0].s, rx_q[0].v, exp_q[0].o, exp_q[0].s, exp_q[0].v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_saturation();
    test_accumulate();
    test_rounding();
    test_backpressure();
    test_random();
    test_overflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
